// File: rtl/menu_ctrl_pkg.sv
// Shared definitions for the menu controller and the menu drawing stage:
// FSM state encoding, default highlight geometry and button indices.
package menu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_RUN     = 2'd2
  } menu_state_t;

  // Default geometry, in screen lines / pixels
  localparam int DEF_V_MIN  = 100;
  localparam int DEF_ITEM_H = 50;
  localparam int DEF_H_MIN  = 448;
  localparam int DEF_H_MAX  = 1472;

  // Bit positions of the buttons inside the packed button vectors
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_BACK = 3;
  localparam int N_BTN    = 4;

  // Top line of entry idx; arithmetic deliberately kept at 12 bits
  function automatic logic [11:0] item_top(input logic [11:0] v_min,
                                           input logic [11:0] item_h,
                                           input logic [1:0]  idx);
    return v_min + ({10'd0, idx} * item_h);
  endfunction

endpackage

// File: rtl/menu_ctrl_btn_debounce.sv
// Raw asynchronous button -> 2-flop synchronizer -> stable-count debouncer
// -> one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_pclk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after DEB_CYCLES equal samples
  // that differ from the current debounced level; pulse on a new 1.
  always_ff @(posedge i_pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: reset is synchronous; all state, including the synchronizer,
    // clears so no pre-reset press can surface afterwards.
    if (!i_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      o_rise <= 1'b0;
    end else begin
      sync1  <= i_btn;
      sync2  <= sync1;
      o_rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level  <= sync2;
        cnt    <= '0;
        o_rise <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// Menu controller: debounced buttons drive a MENU/CONFIRM/RUN FSM and a
// shadow cursor; visible selection and highlight commit once per frame.
module menu_ctrl
  import menu_ctrl_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_H     = DEF_ITEM_H,
  parameter int V_MIN      = DEF_V_MIN,
  parameter int H_MIN      = DEF_H_MIN,
  parameter int H_MAX      = DEF_H_MAX,
  parameter int DEB_CYCLES = 16
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_sel,
  input  logic        i_btn_back,
  input  logic        i_vblnk,
  output logic [1:0]  o_item,
  output logic [11:0] o_hl_v_min,
  output logic [11:0] o_hl_v_max,
  output logic [11:0] o_hl_h_min,
  output logic [11:0] o_hl_h_max,
  output logic        o_menu_en,
  output logic        o_confirm,
  output logic        o_start
);

  localparam logic [1:0]  LAST_ITEM = 2'(N_ITEMS - 1);
  localparam logic [11:0] V_MIN_W   = 12'(V_MIN);
  localparam logic [11:0] ITEM_H_W  = 12'(ITEM_H);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_ev;

  menu_state_t state, state_n;
  logic [1:0]  cursor, cursor_n;
  logic        start_n;
  logic        vblnk_q;
  logic        vblnk_rise;

  assign btn_raw[BTN_UP]   = i_btn_up;
  assign btn_raw[BTN_DOWN] = i_btn_down;
  assign btn_raw[BTN_SEL]  = i_btn_sel;
  assign btn_raw[BTN_BACK] = i_btn_back;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_pclk (i_pclk),
      .i_rst_n(i_rst_n),
      .i_btn  (btn_raw[g]),
      .o_rise (btn_ev[g])
    );
  end

  assign o_hl_h_min = 12'(H_MIN);
  assign o_hl_h_max = 12'(H_MAX);
  assign vblnk_rise = i_vblnk & ~vblnk_q;

  // FSM state, shadow cursor and start pulse registers
  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      state   <= ST_MENU;
      cursor  <= 2'd0;
      o_start <= 1'b0;
    end else begin
      state   <= state_n;
      cursor  <= cursor_n;
      o_start <= start_n;
    end
  end

  // Next state and cursor; priority back > sel > up/down, up+down cancel
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_n  = state;
    cursor_n = cursor;
    start_n  = 1'b0;
    unique case (state)
      ST_MENU: begin
        if (btn_ev[BTN_BACK]) begin
          state_n = ST_MENU;
        end else if (btn_ev[BTN_SEL]) begin
          state_n = ST_CONFIRM;
        end else if (btn_ev[BTN_UP] && !btn_ev[BTN_DOWN]) begin
          cursor_n = (cursor == 2'd0) ? LAST_ITEM : cursor - 2'd1;
        end else if (btn_ev[BTN_DOWN] && !btn_ev[BTN_UP]) begin
          cursor_n = (cursor == LAST_ITEM) ? 2'd0 : cursor + 2'd1;
        end
      end
      ST_CONFIRM: begin
        if (btn_ev[BTN_BACK]) begin
          state_n = ST_MENU;
        end else if (btn_ev[BTN_SEL]) begin
          state_n = ST_RUN;
          start_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (btn_ev[BTN_BACK]) state_n = ST_MENU;
      end
      default: state_n = ST_MENU;
    endcase
  end

  // Frame commit: publish cursor, highlight and mode flags at vblank start
  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      vblnk_q    <= 1'b0;
      o_item     <= 2'd0;
      o_hl_v_min <= V_MIN_W;
      o_hl_v_max <= V_MIN_W + ITEM_H_W;
      o_menu_en  <= 1'b1;
      o_confirm  <= 1'b0;
    end else begin
      vblnk_q <= i_vblnk;
      if (vblnk_rise) begin
        o_item     <= cursor;
        o_hl_v_min <= item_top(V_MIN_W, ITEM_H_W, cursor);
        o_hl_v_max <= item_top(V_MIN_W, ITEM_H_W, cursor) + ITEM_H_W;
        o_menu_en  <= (state != ST_RUN);
        o_confirm  <= (state == ST_CONFIRM);
      end
    end
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// Self-checking bench for menu_ctrl: directed steps followed by random
// button activity, compared against a press-level behavioural model.
module tb_menu_ctrl;

  localparam int DEB = 4;

  logic        i_pclk = 1'b0;
  logic        i_rst_n;
  logic        i_btn_up, i_btn_down, i_btn_sel, i_btn_back;
  logic        i_vblnk;
  logic [1:0]  o_item;
  logic [11:0] o_hl_v_min, o_hl_v_max, o_hl_h_min, o_hl_h_max;
  logic        o_menu_en, o_confirm, o_start;

  menu_ctrl #(.DEB_CYCLES(DEB)) dut (
    .i_pclk    (i_pclk),
    .i_rst_n   (i_rst_n),
    .i_btn_up  (i_btn_up),
    .i_btn_down(i_btn_down),
    .i_btn_sel (i_btn_sel),
    .i_btn_back(i_btn_back),
    .i_vblnk   (i_vblnk),
    .o_item    (o_item),
    .o_hl_v_min(o_hl_v_min),
    .o_hl_v_max(o_hl_v_max),
    .o_hl_h_min(o_hl_h_min),
    .o_hl_h_max(o_hl_h_max),
    .o_menu_en (o_menu_en),
    .o_confirm (o_confirm),
    .o_start   (o_start)
  );

  always #5 i_pclk = ~i_pclk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cycles = 0;

  // Count every clock cycle in which o_start is high
  always @(posedge i_pclk) begin
    #1;
    if (o_start === 1'b1) start_cycles++;
  end

  // Behavioural model: 0 = menu, 1 = confirm, 2 = run
  int m_cursor, m_state, m_item, m_menu_en, m_confirm, m_starts;

  task automatic m_reset();
    m_cursor = 0; m_state = 0; m_item = 0;
    m_menu_en = 1; m_confirm = 0; m_starts = 0;
  endtask

  // Apply one set of simultaneous press events (mask: up,down,sel,back)
  task automatic m_events(input logic [3:0] mask);
    if (mask[3]) begin
      m_state = 0;
    end else if (mask[2]) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin m_state = 2; m_starts++; end
    end else if (m_state == 0 && (mask[0] != mask[1])) begin
      if (mask[0]) m_cursor = (m_cursor + 3) % 4;
      else         m_cursor = (m_cursor + 1) % 4;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    assert (got === 32'(exp)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".item"},    32'(o_item),     m_item);
    check({tag, ".vmin"},    32'(o_hl_v_min), 100 + m_item * 50);
    check({tag, ".vmax"},    32'(o_hl_v_max), 150 + m_item * 50);
    check({tag, ".menu_en"}, 32'(o_menu_en),  m_menu_en);
    check({tag, ".confirm"}, 32'(o_confirm),  m_confirm);
    check({tag, ".starts"},  32'(start_cycles), m_starts);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_pclk);
  endtask

  // Hold the buttons in mask for 'hold' cycles, release, let it settle
  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge i_pclk);
    {i_btn_back, i_btn_sel, i_btn_down, i_btn_up} = mask;
    tick(hold);
    {i_btn_back, i_btn_sel, i_btn_down, i_btn_up} = 4'b0;
    tick(14);
    if (hold >= DEB) m_events(mask);
  endtask

  task automatic vblank();
    @(negedge i_pclk);
    i_vblnk = 1'b1;
    tick(3);
    i_vblnk = 1'b0;
    tick(2);
    m_item    = m_cursor;
    m_menu_en = (m_state != 2) ? 1 : 0;
    m_confirm = (m_state == 1) ? 1 : 0;
  endtask

  initial begin
    logic [3:0] mask;
    int r;
    i_rst_n = 1'b0;
    {i_btn_back, i_btn_sel, i_btn_down, i_btn_up} = 4'b0;
    i_vblnk = 1'b0;
    m_reset();
    tick(3);

    // Reset values
    check_all("rst");
    check("rst.start", 32'(o_start), 0);
    check("rst.hmin", 32'(o_hl_h_min), 448);
    check("rst.hmax", 32'(o_hl_h_max), 1472);
    i_rst_n = 1'b1;
    tick(2);

    vblank();
    check_all("vb0");

    // Short press is filtered, long press moves exactly once
    press(4'b0010, 3);
    vblank();
    check_all("short_down");
    press(4'b0010, 10);
    vblank();
    check_all("long_down");

    // Wrap-around both directions
    press(4'b0001, 10);
    press(4'b0001, 10);
    vblank();
    check_all("wrap_up");
    press(4'b0010, 10);
    vblank();
    check_all("wrap_down");

    // Three moves in one frame commit as a single step
    press(4'b0010, 10);
    press(4'b0010, 10);
    press(4'b0010, 10);
    check("collapse.pre", 32'(o_item), 0);
    vblank();
    check_all("collapse");

    // Confirm, start, run, back
    press(4'b0100, 10);
    vblank();
    check_all("confirm");
    press(4'b0100, 10);
    check("start.pulse", 32'(start_cycles), m_starts);
    vblank();
    check_all("run");
    press(4'b1000, 10);
    vblank();
    check_all("back");

    // Simultaneous events
    press(4'b0011, 10);
    vblank();
    check_all("up_down");
    press(4'b1100, 10);
    vblank();
    check_all("sel_back");

    // Reset while running
    press(4'b0100, 10);
    press(4'b0100, 10);
    vblank();
    check_all("run2");
    @(negedge i_pclk);
    i_rst_n = 1'b0;
    @(negedge i_pclk);
    m_reset();
    m_starts = start_cycles - 0;
    check("rst_run.item", 32'(o_item), 0);
    check("rst_run.vmin", 32'(o_hl_v_min), 100);
    check("rst_run.vmax", 32'(o_hl_v_max), 150);
    check("rst_run.menu_en", 32'(o_menu_en), 1);
    check("rst_run.confirm", 32'(o_confirm), 0);
    check("rst_run.start", 32'(o_start), 0);
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    vblank();
    check_all("after_rst");

    // Random button activity
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: mask = 4'b0010;
        3, 4:    mask = 4'b0001;
        5:       mask = 4'b0100;
        6:       mask = 4'b1000;
        7:       mask = 4'(1 << $urandom_range(0, 3));
        8:       mask = 4'($urandom_range(1, 15));
        default: mask = 4'b0000;
      endcase
      if (r == 7)      press(mask, $urandom_range(1, 3));
      else if (r != 9) press(mask, $urandom_range(7, 15));
      if (r == 9 || $urandom_range(0, 1) == 1) begin
        vblank();
        check_all("rnd");
      end else begin
        check("rnd.hold", 32'(o_item), m_item);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
MENU_CTRL -- requirements
Module: menu_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_ITEMS, 4, number of menu entries.
- ITEM_H, 50, entry height in lines.
- V_MIN, 100, top line of entry 0.
- H_MIN, 448, highlight left edge.
- H_MAX, 1472, highlight right edge (exclusive).
- DEB_CYCLES, 16, debounce stable-cycle count.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_pclk, in, 1, pixel clock.
- i_rst_n, in, 1, reset.
- i_btn_up, in, 1, raw async button.
- i_btn_down, in, 1, raw async button.
- i_btn_sel, in, 1, raw async button.
- i_btn_back, in, 1, raw async button.
- i_vblnk, in, 1, vertical blank from timing chain.
- o_item, out, 2, committed selected entry index.
- o_hl_v_min, out, 12, committed highlight top line.
- o_hl_v_max, out, 12, committed highlight bottom line (exclusive).
- o_hl_h_min, out, 12, constant H_MIN.
- o_hl_h_max, out, 12, constant H_MAX.
- o_menu_en, out, 1, menu overlay enable for the draw stage.
- o_confirm, out, 1, confirm prompt active.
- o_start, out, 1, one-cycle game start pulse.
REQ-003 One clock, i_pclk; reset i_rst_n is synchronous and active-low.

Function
REQ-004 Each button SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level only after DEB_CYCLES consecutive equal synchronized samples.
REQ-005 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; the debounced 1->0 edge produces no event; holding a button produces no repeat.
REQ-006 The FSM SHALL have three states: MENU, CONFIRM and RUN.
REQ-007 In MENU, an up event decrements the cursor, wrapping 0 -> N_ITEMS-1.
REQ-008 In MENU, a down event increments the cursor, wrapping N_ITEMS-1 -> 0.
REQ-009 In MENU, a sel event moves the FSM to CONFIRM; a back event is ignored.
REQ-010 In CONFIRM, a sel event moves the FSM to RUN and asserts o_start for exactly one cycle on the transition; a back event returns to MENU with the cursor unchanged; up and down are ignored.
REQ-011 In RUN, a back event returns to MENU with the cursor unchanged; all other events are ignored.
REQ-012 If more than one event occurs in the same cycle, priority is back > sel > up/down; simultaneous up and down cancel (no move).
REQ-013 The cursor is a shadow register. o_item, o_hl_v_min and o_hl_v_max SHALL update only on the cycle after a detected i_vblnk 0->1 edge, with o_hl_v_min = V_MIN + o_item*ITEM_H and o_hl_v_max = o_hl_v_min + ITEM_H, computed at 12-bit width.
REQ-014 o_menu_en SHALL be 1 in MENU and CONFIRM and 0 in RUN, and o_confirm SHALL be 1 only in CONFIRM; both are registered and update at the same vblank edge as REQ-013. o_start is not frame-aligned.
REQ-015 Several cursor moves within one frame SHALL collapse, so that only the final cursor value is committed.

Reset
REQ-016 While i_rst_n=0 at a clock edge:
- FSM enters MENU; cursor=0.
- o_item=0, o_hl_v_min=V_MIN, o_hl_v_max=V_MIN+ITEM_H.
- o_menu_en=1, o_confirm=0, o_start=0.
- Debounced levels and synchronizers = 0; debounce counters = 0; vblank edge register = 0.
REQ-017 A reset asserted mid-operation, including in RUN or during an o_start cycle, SHALL take effect at the next clock edge; no event pending before reset SHALL act after reset release.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the default geometry constants (V_MIN, ITEM_H, H_MIN, H_MAX); they are shared with the menu drawing stage.
REQ-019 A sub-module btn_debounce (synchronizer, debounce counter, rise pulse) SHALL be instantiated four times; the FSM, shadow cursor and frame commit live in menu_ctrl.

Verification (DEB_CYCLES=4 in bench)
REQ-020 Reset, then one vblank edge -> o_item=0, o_hl_v_min=100, o_hl_v_max=150, o_menu_en=1, o_start=0.
REQ-021 Down press held 3 cycles then released, then vblank -> no move; held 10 cycles -> exactly one move; after vblank o_item=1, o_hl_v_min=150, o_hl_v_max=200.
REQ-022 Up press from cursor 0, then vblank -> o_item=3, o_hl_v_min=250; down press from 3 -> o_item=0.
REQ-023 Three down presses in one frame -> outputs unchanged until vblank, then o_item=3 in one step.
REQ-024 Sel, then vblank -> o_confirm=1. Sel again -> o_start high exactly 1 cycle; after vblank o_menu_en=0. Back, then vblank -> o_menu_en=1 and o_item retained.
REQ-025 Up and down debounced in the same cycle -> cursor unchanged; sel and back in the same cycle while in MENU -> state stays MENU; i_rst_n low in RUN -> REQ-016 values at the next edge.
